// File: rtl/pdp8_iot_ctl.sv
// rtl/pdp8_iot_ctl.sv - PDP-8 IOT bus controller: device decode, strobe/timeout handshake, interrupt priority
//
// Optional feature macro: IRQ_MASK_EN
//   When defined, device code CTL_CODE addresses this controller:
//   mb[2:0]==1 loads the interrupt mask from cpu_ac, and mb[2:0]==2 reads the mask back on cpu_data.
//   When undefined, the mask is fixed at all-ones and CTL_CODE is an ordinary unmatched code.
//
// Ports
//   clk, reset      clock and synchronous active-low reset
//   iot, state      CPU is executing an IOT, and the CPU major state
//   mb, cpu_ac      IOT instruction word, and the accumulator (used only for the mask load)
//   io_select       latched device code, broadcast to all devices
//   dev_strobe      one-hot select of the addressed device
//   dev_data_in     per-device read data; device k is at [12k+11:12k]
//   dev_data_avail  per-device read-data-valid
//   dev_skip        per-device skip request
//   dev_interrupt   per-device interrupt level
//   cpu_data        captured read data; cpu_data_avail marks it valid
//   cpu_skip        sticky skip result of the current IOT
//   iot_done        one-cycle completion pulse
//   iot_nodev       with iot_done, reports no matching device or a timeout
//   cpu_interrupt   OR of the enabled pending requests
//   irq_id          lowest-numbered enabled pending device

module pdp8_iot_ctl #(
    parameter int                NDEV       = 4,
    parameter logic [6*NDEV-1:0] DEV_CODES  = {6'o02, 6'o01, 6'o04, 6'o03},
    parameter logic [5:0]        CTL_CODE   = 6'o77,
    parameter logic [3:0]        EXEC_STATE = 4'd1,
    parameter int                TIMEOUT    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iot,
    input  logic [3:0]           state,
    input  logic [11:0]          mb,
    input  logic [11:0]          cpu_ac,
    output logic [5:0]           io_select,
    output logic [NDEV-1:0]      dev_strobe,
    input  logic [12*NDEV-1:0]   dev_data_in,
    input  logic [NDEV-1:0]      dev_data_avail,
    input  logic [NDEV-1:0]      dev_skip,
    input  logic [NDEV-1:0]      dev_interrupt,
    output logic [11:0]          cpu_data,
    output logic                 cpu_data_avail,
    output logic                 cpu_skip,
    output logic                 iot_done,
    output logic                 iot_nodev,
    output logic                 cpu_interrupt,
    output logic [2:0]           irq_id
);
    localparam int         SEL_W    = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_DONE,
        S_HOLD
    } fsm_t;

    fsm_t             fsm, fsm_next;
    logic             exec_cond, start_d, start;
    logic             hit, ctl_hit;
    logic [SEL_W-1:0] hit_idx, sel;
    logic [7:0]       timer;
    logic [NDEV-1:0]  mask, pend;
    logic [2:0]       pend_id;
    logic [11:0]      data_arr [NDEV];
    logic             unused_bits;

    // Edge-detect the raw execute condition so a held IOT runs only once.
    assign exec_cond = iot && (state == EXEC_STATE);
    assign start     = exec_cond && !start_d;

    // Table lookup on the live instruction word; lowest matching entry wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NDEV - 1; k >= 0; k--) begin
            if (mb[8:3] == DEV_CODES[6*k +: 6]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(k);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NDEV; k++) begin
            data_arr[k] = dev_data_in[12*k +: 12];
        end
    end

    always_comb begin
        pend_id = 3'd0;
        for (int k = NDEV - 1; k >= 0; k--) begin
            if (pend[k]) pend_id = 3'(k);
        end
    end

`ifdef IRQ_MASK_EN
    // The controller's own code shadows any table entry with the same value.
    assign ctl_hit = (mb[8:3] == CTL_CODE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            mask <= '1;
        end else if (fsm == S_IDLE && start && ctl_hit && mb[2:0] == 3'o1) begin
            mask <= cpu_ac[NDEV-1:0];
        end
    end
`else
    assign ctl_hit = 1'b0;
    assign mask    = '1;
`endif

    always_comb begin
        fsm_next   = fsm;
        dev_strobe = '0;
        iot_done   = 1'b0;
        case (fsm)
            S_IDLE:   if (start) fsm_next = (hit && !ctl_hit) ? S_STROBE : S_DONE;
            S_STROBE: begin
                dev_strobe[sel] = 1'b1;
                fsm_next        = S_WAIT;
            end
            S_WAIT:   begin
                dev_strobe[sel] = 1'b1;
                if (dev_data_avail[sel] || timer == TMO_LAST) fsm_next = S_DONE;
            end
            S_DONE:   begin
                iot_done = 1'b1;
                fsm_next = S_HOLD;
            end
            S_HOLD:   if (!exec_cond) fsm_next = S_IDLE;
            default:  fsm_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm            <= S_IDLE;
            start_d        <= 1'b0;
            io_select      <= '0;
            sel            <= '0;
            timer          <= '0;
            cpu_data       <= '0;
            cpu_data_avail <= 1'b0;
            cpu_skip       <= 1'b0;
            iot_nodev      <= 1'b0;
            pend           <= '0;
            cpu_interrupt  <= 1'b0;
            irq_id         <= '0;
        end else begin
            fsm           <= fsm_next;
            start_d       <= exec_cond;
            // Two-stage interrupt path: request -> pend -> cpu_interrupt/irq_id.
            pend          <= dev_interrupt & mask;
            cpu_interrupt <= |pend;
            irq_id        <= pend_id;
            case (fsm)
                S_IDLE: begin
                    if (start) begin
                        io_select      <= mb[8:3];
                        sel            <= hit_idx;
                        cpu_data_avail <= 1'b0;
                        cpu_skip       <= 1'b0;
                        iot_nodev      <= !(hit || ctl_hit);
`ifdef IRQ_MASK_EN
                        if (ctl_hit && mb[2:0] == 3'o2) begin
                            cpu_data       <= 12'(mask);
                            cpu_data_avail <= 1'b1;
                        end
`endif
                    end
                end
                S_STROBE: timer <= '0;
                S_WAIT: begin
                    cpu_skip <= cpu_skip | dev_skip[sel];
                    if (dev_data_avail[sel]) begin
                        cpu_data       <= data_arr[sel];
                        cpu_data_avail <= 1'b1;
                    end else if (timer == TMO_LAST) begin
                        iot_nodev <= 1'b1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign unused_bits = ^{mb[11:9], mb[2:0], cpu_ac};

endmodule
